// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared receiver states, scancode prefixes and the set-2 to ZX matrix lookup.
package ps2_kbd_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_AA = 8'hAA;
    localparam logic [7:0] PFX_FC = 8'hFC;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    // Octal literal 6'oRC encodes row R, column C of the membrane.
    function automatic key_pos_t key_lookup(input logic [7:0] code, input logic ext);
        logic [5:0] rc;
        logic       hit;
        hit = 1'b1;
        case (code)
            8'h12, 8'h59: rc = 6'o00;
            8'h1A: rc = 6'o01;
            8'h22: rc = 6'o02;
            8'h21: rc = 6'o03;
            8'h2A: rc = 6'o04;
            8'h1C: rc = 6'o10;
            8'h1B: rc = 6'o11;
            8'h23: rc = 6'o12;
            8'h2B: rc = 6'o13;
            8'h34: rc = 6'o14;
            8'h15: rc = 6'o20;
            8'h1D: rc = 6'o21;
            8'h24: rc = 6'o22;
            8'h2D: rc = 6'o23;
            8'h2C: rc = 6'o24;
            8'h16: rc = 6'o30;
            8'h1E: rc = 6'o31;
            8'h26: rc = 6'o32;
            8'h25: rc = 6'o33;
            8'h2E: rc = 6'o34;
            8'h45: rc = 6'o40;
            8'h46: rc = 6'o41;
            8'h3E: rc = 6'o42;
            8'h3D: rc = 6'o43;
            8'h36: rc = 6'o44;
            8'h4D: rc = 6'o50;
            8'h44: rc = 6'o51;
            8'h43: rc = 6'o52;
            8'h3C: rc = 6'o53;
            8'h35: rc = 6'o54;
            8'h5A: rc = 6'o60;
            8'h4B: rc = 6'o61;
            8'h42: rc = 6'o62;
            8'h3B: rc = 6'o63;
            8'h33: rc = 6'o64;
            8'h29: rc = 6'o70;
            8'h14: rc = 6'o71;
            8'h3A: rc = 6'o72;
            8'h31: rc = 6'o73;
            8'h32: rc = 6'o74;
            default: begin
                rc  = 6'o00;
                hit = 1'b0;
            end
        endcase
        // Keypad Enter (E0 5A) and right Ctrl (E0 14) share their plain-key positions.
        key_lookup.hit = hit & (~ext | code == 8'h5A | code == 8'h14);
        key_lookup.row = rc[5:3];
        key_lookup.col = rc[2:0];
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 frame receiver.
//   clkcpu, rst_n       : CPU clock, async active-low reset
//   ps2_clk, ps2_dat    : raw asynchronous PS/2 lines
//   code, code_valid    : received byte and its one-cycle strobe (odd parity and stop bit good)
module ps2_keyboard_rx
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 3500,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid
);
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev, fall, dat;
    rx_state_t              state;
    logic [2:0]             cnt;
    logic [7:0]             sr;
    logic                   par;
    logic [11:0]            tmo;

    assign dat  = dat_sync[SYNC_STAGES-1];
    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];

    always_ff @(posedge clkcpu or negedge rst_n)
        if (!rst_n) begin
            clk_sync   <= '1;
            dat_sync   <= '1;
            clk_prev   <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            sr         <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync   <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            code_valid <= 1'b0;
            // An edge takes priority over an expiring timeout in the same cycle.
            if (fall) begin
                tmo <= '0;
                case (state)
                    RX_IDLE: begin
                        cnt   <= '0;
                        state <= dat ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: begin
                        sr    <= {dat, sr[7:1]};
                        cnt   <= cnt + 3'd1;
                        state <= cnt == 3'd7 ? RX_PARITY : RX_DATA;
                    end
                    RX_PARITY: begin
                        par   <= dat;
                        state <= RX_STOP;
                    end
                    default: begin
                        code_valid <= dat & ^{sr, par};
                        code       <= sr;
                        state      <= RX_IDLE;
                    end
                endcase
            end else if (state != RX_IDLE) begin
                if (tmo == 12'(TIMEOUT_CYCLES - 1))
                    state <= RX_IDLE;
                else
                    tmo <= tmo + 12'd1;
            end
        end
endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 set-2 keyboard to ZX Spectrum 8x5 key matrix.
//   clkcpu, rst_n     : CPU clock, async active-low reset
//   ps2_clk, ps2_dat  : PS/2 lines
//   addr_hi           : CPU a[15:8], a low bit selects that matrix row
//   kd                : active-low key columns for the selected rows
//   reset_req         : high while Ctrl+Alt+Del are held
module ps2_keyboard
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 3500,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic       reset_req
);
    logic [7:0]       code;
    logic             code_valid;
    logic [7:0][4:0]  key, eff;
    logic [3:0]       arr;
    logic             alt, ctrl, del, ext, brk;
    logic [4:0]       hit;
    key_pos_t         pos;

    ps2_keyboard_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_rx (
        .clkcpu    (clkcpu),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .code      (code),
        .code_valid(code_valid)
    );

    assign pos = key_lookup(code, ext);

    // arr = {right, up, down, left}
    always_ff @(posedge clkcpu or negedge rst_n)
        if (!rst_n) begin
            key       <= '0;
            arr       <= '0;
            alt       <= 1'b0;
            ctrl      <= 1'b0;
            del       <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            reset_req <= 1'b0;
        end else begin
            reset_req <= ctrl & alt & del;
            if (code_valid) begin
                if (code == PFX_E0)
                    ext <= 1'b1;
                else if (code == PFX_F0)
                    brk <= 1'b1;
                else if (code == PFX_AA || code == PFX_FC) begin
                    key  <= '0;
                    arr  <= '0;
                    alt  <= 1'b0;
                    ctrl <= 1'b0;
                    del  <= 1'b0;
                end else begin
                    if (pos.hit) key[pos.row][pos.col] <= ~brk;
                    if (code == 8'h11) alt <= ~brk;
                    if (code == 8'h14) ctrl <= ~brk;
                    if (ext) begin
                        if (code == 8'h71) del <= ~brk;
                        if (code == 8'h6B) arr[0] <= ~brk;
                        if (code == 8'h72) arr[1] <= ~brk;
                        if (code == 8'h75) arr[2] <= ~brk;
                        if (code == 8'h74) arr[3] <= ~brk;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end

    // Arrows press CS plus 5/6/7/8, layered over the physical keys.
    always_comb begin
        eff       = key;
        eff[0][0] = key[0][0] | (|arr);
        eff[3][4] = key[3][4] | arr[0];
        eff[4][4] = key[4][4] | arr[1];
        eff[4][3] = key[4][3] | arr[2];
        eff[4][2] = key[4][2] | arr[3];
        hit       = '0;
        for (int r = 0; r < 8; r++)
            hit = hit | (eff[r] & {5{~addr_hi[r]}});
        kd = ~hit;
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed self-checking bench for ps2_keyboard.
module tb_ps2_keyboard;
    import ps2_kbd_pkg::*;

    logic       clkcpu = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] addr_hi = 8'hFF;
    logic [4:0] kd;
    logic       reset_req;
    int         total = 0;
    int         bad = 0;

    ps2_keyboard dut (
        .clkcpu   (clkcpu),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .addr_hi  (addr_hi),
        .kd       (kd),
        .reset_req(reset_req)
    );

    always #5 clkcpu = ~clkcpu;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_kd(input string tag, input logic [7:0] a, input logic [4:0] exp);
        @(negedge clkcpu);
        addr_hi = a;
        #1;
        chk(tag, {3'b0, kd}, {3'b0, exp});
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clkcpu);
        ps2_dat = b;
        repeat (10) @(negedge clkcpu);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clkcpu);
        ps2_clk = 1'b1;
    endtask

    // Frame: start, 8 data LSB first, odd parity, stop. Only the first n bits are sent.
    task automatic send(input logic [7:0] c, input logic bp = 1'b0, input logic bs = 1'b0,
                        input int n = 11);
        logic [10:0] f;
        f = {~bs, ~^c ^ bp, c, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clkcpu);
    endtask

    initial begin
        repeat (3) @(negedge clkcpu);
        chk_kd("reset_kd", 8'h00, 5'h1F);
        chk("reset_req_rst", {7'b0, reset_req}, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clkcpu);

        send(8'h1C);
        chk_kd("A_make", 8'hFD, 5'h1E);
        chk_kd("A_unsel", 8'hFF, 5'h1F);
        send(8'hF0);
        send(8'h1C);
        chk_kd("A_break", 8'hFD, 5'h1F);

        send(8'hE0);
        send(8'h75);
        chk_kd("up_cs", 8'hFE, 5'h1E);
        chk_kd("up_7", 8'hEF, 5'h17);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk_kd("up_rel_cs", 8'hFE, 5'h1F);
        chk_kd("up_rel_7", 8'hEF, 5'h1F);

        send(8'h1C, 1'b1);
        chk_kd("bad_parity", 8'hFD, 5'h1F);
        send(8'h1C, 1'b0, 1'b1);
        chk_kd("bad_stop", 8'hFD, 5'h1F);

        send(8'h1C, 1'b0, 1'b0, 4);
        repeat (3600) @(negedge clkcpu);
        send(8'h1B);
        chk_kd("timeout_S", 8'hFD, 5'h1D);
        send(8'hF0);
        send(8'h1B);
        chk_kd("S_break", 8'hFD, 5'h1F);

        send(8'h14);
        send(8'h11);
        chk("rr_before_del", {7'b0, reset_req}, 8'h00);
        send(8'hE0);
        send(8'h71);
        chk("rr_cad", {7'b0, reset_req}, 8'h01);
        send(8'hF0);
        send(8'h11);
        chk("rr_alt_up", {7'b0, reset_req}, 8'h00);

        send(8'h12);
        send(8'h29);
        chk_kd("hold_cs", 8'hFE, 5'h1E);
        chk_kd("hold_sp_ss", 8'h7F, 5'h1C);
        send(8'hAA);
        chk_kd("aa_clear", 8'h00, 5'h1F);
        send(8'h11);
        chk("rr_aa_cleared", {7'b0, reset_req}, 8'h00);
        send(8'hF0);
        send(8'h11);

        send(8'h1C);
        chk_kd("pre_rst_A", 8'hFD, 5'h1E);
        send(8'h1B, 1'b0, 1'b0, 5);
        chk("mid_frame", {6'b0, dut.u_rx.state}, {6'b0, RX_DATA});
        @(negedge clkcpu);
        rst_n = 1'b0;
        repeat (3) @(negedge clkcpu);
        chk("rst_idle", {6'b0, dut.u_rx.state}, {6'b0, RX_IDLE});
        chk_kd("rst_kd", 8'h00, 5'h1F);
        rst_n = 1'b1;
        repeat (5) @(negedge clkcpu);
        send(8'h1B);
        chk_kd("post_rst_S", 8'hFD, 5'h1D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
